multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM that turns the single-cycle RV32I datapath into a multicycle core.
//  - One shared instruction/data memory is reached through a req/ready handshake.
//  - Sequences fetch, decode, execute, memory access and writeback.
//  - Drives every datapath mux select, write enable and alu_op; counts retired instructions.
// PARAMETERS
//  CNT_W     32  width of the instret counter
//  MAX_WAIT  16  max cycles mem_req may wait for mem_ready before bus error (>=1)
// PORTS
//  clk                       in   1      core clock
//  reset                     in   1      asynchronous, active-low reset
//  opcode                    in   7      IR[6:0] (registered IR, valid from DECODE on)
//  funct3                    in   3      IR[14:12]
//  funct7                    in   7      IR[31:25]
//  alu_eq                    in   1      ALU equality flag (branch compare)
//  mem_ready                 in   1      memory completes the current request this cycle
//  mem_req                   out  1      memory request
//  mem_we                    out  1      request is a write (SW)
//  mem_addr_sel              out  1      0 = PC (fetch), 1 = ALU result (data)
//  ir_write                  out  1      latch fetched word into IR
//  pc_write                  out  1      load PC from pc_in mux
//  pc_in_mux_sel             out  3      PC_PLUS_4 / JAL_ADDR / ALU_RESULT / BEQ_OR_BNE_ADDR
//  reg_write                 out  1      register file write enable
//  register_data_in_mux_sel  out  2      ALU_RESULT / MEMORY_DATA / PC_PLUS_4
//  alu_op                    out  4      alu_op_t
//  use_imm                   out  1      ALU b input = imm_ext
//  sign_extend_type          out  3      sign_extend_t
//  instret                   out  CNT_W  retired-instruction count
//  bus_error                 out  1      sticky: memory timeout occurred
// BEHAVIOUR
//  Reset: state=FETCH, instret=0, bus_error=0, wait_cnt=0.
//   - Every output is 0 while reset is low; an in-flight mem_req drops asynchronously.
//  States: FETCH, DECODE, EXECUTE, MEM_READ, MEM_WRITE, WRITEBACK, ERROR.
//  FETCH
//   - mem_req=1, mem_addr_sel=0.
//   - On mem_ready: ir_write=1 -> DECODE. Otherwise stay.
//  DECODE: one cycle, operands settle -> EXECUTE.
//  EXECUTE
//   - ALU reg/imm, LUI: compute -> WRITEBACK.
//   - LW -> MEM_READ. SW -> MEM_WRITE.
//   - BEQ/BNE: pc_write=1; sel=BEQ_OR_BNE_ADDR if taken, else PC_PLUS_4 -> FETCH.
//   - JAL/JALR: reg_write=1, data sel=PC_PLUS_4 (old PC), pc_write=1 (JAL_ADDR / ALU_RESULT) -> FETCH.
//   - Unsupported opcode: NOP, pc_write=1 with PC_PLUS_4 -> FETCH.
//  MEM_READ: mem_req=1, mem_addr_sel=1; on mem_ready -> WRITEBACK with data sel=MEMORY_DATA.
//  MEM_WRITE
//   - mem_req=1, mem_we=1, mem_addr_sel=1.
//   - On mem_ready: pc_write=1 (PC_PLUS_4) -> FETCH.
//  WRITEBACK: reg_write=1, pc_write=1 (PC_PLUS_4) -> FETCH.
//  Handshake: once raised, mem_req/mem_we/mem_addr_sel hold stable until the mem_ready cycle.
//   - mem_ready while mem_req=0 is ignored.
//  Timeout
//   - wait_cnt increments each cycle mem_req=1 && mem_ready=0; it clears on mem_ready.
//   - wait_cnt==MAX_WAIT-1 with no ready -> ERROR next cycle.
//   - ERROR: bus_error=1, all enables 0, stays until reset.
//  instret: +1 in every cycle with pc_write=1 (exactly once per instruction); wraps modulo 2^CNT_W.
//  Latency, zero-wait memory, in cycles:
//   - ALU/LUI = 4, LW = 5, SW = 4, branch/jump = 3.
//  Datapath timing: ALU and memory outputs are combinational in the cycle that consumes them.
//   - No operand/result holding registers beyond IR are required.
// CONFIGURATION
//  ILLEGAL_TRAP_EN
//   - Defined: an unsupported opcode in EXECUTE goes to TRAP, asserting output illegal_trap=1.
//     TRAP issues no writes and is sticky until reset; instret does not count it.
//   - Undefined: no TRAP state, no illegal_trap port; unsupported opcodes retire as NOP.
// STRUCTURE
//  cpu_pkg
//   - opcode_t, alu_op_t, sign_extend_t, pc_in_mux_sel_t, register_data_in_mux_sel_t.
//   - mc_state_t (new).
//  Sub-module alu_decode: opcode/funct3/funct7 -> alu_op, use_imm, sign_extend_type.
//   - Combinational; held valid from DECODE on.
//  FSM, wait counter and instret live in this module.
// TESTING
//  1. ADDI x1,x0,5 with mem_ready always 1:
//     FETCH->DECODE->EXECUTE->WRITEBACK; reg_write in cycle 4; instret=1; PC 0->4.
//  2. LW with data-phase mem_ready delayed 3 cycles:
//     MEM_READ held 4 cycles, mem_req stable; total 8 cycles; instret=1.
//  3. BEQ with alu_eq=1 then alu_eq=0:
//     pc_in_mux_sel=BEQ_OR_BNE_ADDR then PC_PLUS_4; both 3 cycles; no reg_write.
//  4. mem_ready stuck 0, MAX_WAIT=16:
//     ERROR after 16 FETCH cycles; bus_error=1, mem_req=0 afterwards; instret unchanged.
//  5. reset low mid-MEM_WRITE:
//     mem_req/mem_we drop immediately; after release, FETCH with instret=0.
//  6. Opcode 7'b1111111:
//     with ILLEGAL_TRAP_EN, illegal_trap=1 and hang; without, retire as NOP (instret+1, PC+4).

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// cpu_pkg: shared RV32I types for the multicycle controller
// Holds opcode, ALU, immediate and mux-select encodings plus the controller state type.
// ILLEGAL_TRAP_EN adds the TRAP state.
package cpu_pkg;
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;
    // Low three bits equal funct3 so R/I decode can pass funct3 straight through.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SLL    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SRL    = 4'd5,
        ALU_OR     = 4'd6,
        ALU_AND    = 4'd7,
        ALU_SUB    = 4'd8,
        ALU_SRA    = 4'd13,
        ALU_PASS_B = 4'd15
    } alu_op_t;
    typedef enum logic [2:0] {SE_I, SE_S, SE_B, SE_U, SE_J} sign_extend_t;
    typedef enum logic [2:0] {
        PC_PLUS_4, PC_JAL_ADDR, PC_ALU_RESULT, PC_BEQ_OR_BNE_ADDR
    } pc_in_mux_sel_t;
    typedef enum logic [1:0] {
        RD_ALU_RESULT, RD_MEMORY_DATA, RD_PC_PLUS_4
    } register_data_in_mux_sel_t;
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM_READ, S_MEM_WRITE, S_WRITEBACK, S_ERROR
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } mc_state_t;
endpackage

// File: rtl/multicycle_controller_alu_decode.sv
// alu_decode: combinational IR field decode for the ALU
// Ports: opcode/funct3/funct7 in; alu_op, use_imm (ALU b = imm), sign_extend_type out.
module alu_decode
    import cpu_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output alu_op_t      alu_op,
    output logic         use_imm,
    output sign_extend_t sign_extend_type
);
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    always_comb begin
        alu_op           = ALU_ADD;
        use_imm          = 1'b0;
        sign_extend_type = SE_I;
        case (opcode_t'(opcode))
            // funct7[5] selects SUB/SRA; ADDI never becomes SUB.
            OP_REG:    alu_op = alu_op_t'({funct7[5] & (funct3 == 3'b000 || funct3 == 3'b101), funct3});
            OP_IMM: begin
                alu_op  = alu_op_t'({funct7[5] & (funct3 == 3'b101), funct3});
                use_imm = 1'b1;
            end
            OP_LOAD:   use_imm = 1'b1;
            OP_STORE: begin
                use_imm          = 1'b1;
                sign_extend_type = SE_S;
            end
            OP_BRANCH: begin
                alu_op           = ALU_SUB;
                sign_extend_type = SE_B;
            end
            OP_JAL:    sign_extend_type = SE_J;
            OP_JALR:   use_imm = 1'b1;
            OP_LUI: begin
                alu_op           = ALU_PASS_B;
                use_imm          = 1'b1;
                sign_extend_type = SE_U;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing an RV32I datapath over a shared memory
// Inputs: clk, reset (async, active-low), opcode/funct3/funct7 from IR, alu_eq, mem_ready.
// Outputs: mem_req/mem_we/mem_addr_sel handshake, ir_write, pc_write, pc_in_mux_sel,
//   reg_write, register_data_in_mux_sel, alu_op/use_imm/sign_extend_type,
//   instret (retired count), bus_error (sticky memory timeout).
// ILLEGAL_TRAP_EN: unsupported opcodes enter a sticky TRAP and raise illegal_trap.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic                      alu_eq,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic                      mem_addr_sel,
    output logic                      ir_write,
    output logic                      pc_write,
    output pc_in_mux_sel_t            pc_in_mux_sel,
    output logic                      reg_write,
    output register_data_in_mux_sel_t register_data_in_mux_sel,
    output alu_op_t                   alu_op,
    output logic                      use_imm,
    output sign_extend_t              sign_extend_type,
    output logic [CNT_W-1:0]          instret,
    output logic                      bus_error
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                      illegal_trap
`endif
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    mc_state_t         state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    alu_op_t           dec_alu_op;
    logic              dec_use_imm;
    sign_extend_t      dec_sext;
    logic              timeout, taken;

    alu_decode u_alu_decode (
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7           (funct7),
        .alu_op           (dec_alu_op),
        .use_imm          (dec_use_imm),
        .sign_extend_type (dec_sext)
    );

    // Only consulted in states that hold mem_req high.
    assign timeout = !mem_ready && wait_cnt == WAIT_W'(MAX_WAIT - 1);
    assign taken   = (funct3 == 3'b000 && alu_eq) || (funct3 == 3'b001 && !alu_eq);

    // Gating by reset keeps every output at 0 while reset is held low.
    assign alu_op           = reset ? dec_alu_op : ALU_ADD;
    assign use_imm          = reset & dec_use_imm;
    assign sign_extend_type = reset ? dec_sext : SE_I;
    assign bus_error        = state == S_ERROR;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_trap     = state == S_TRAP;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= mem_ready ? '0 : mem_req ? wait_cnt + 1'b1 : wait_cnt;
            instret  <= instret + CNT_W'(pc_write);
        end
    end

    always_comb begin
        next_state               = state;
        mem_req                  = 1'b0;
        mem_we                   = 1'b0;
        mem_addr_sel             = 1'b0;
        ir_write                 = 1'b0;
        pc_write                 = 1'b0;
        pc_in_mux_sel            = PC_PLUS_4;
        reg_write                = 1'b0;
        register_data_in_mux_sel = RD_ALU_RESULT;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ir_write   = mem_ready;
                    next_state = mem_ready ? S_DECODE : timeout ? S_ERROR : S_FETCH;
                end
                S_DECODE: next_state = S_EXECUTE;
                S_EXECUTE: begin
                    case (opcode_t'(opcode))
                        OP_REG, OP_IMM, OP_LUI: next_state = S_WRITEBACK;
                        OP_LOAD:                next_state = S_MEM_READ;
                        OP_STORE:               next_state = S_MEM_WRITE;
                        OP_BRANCH: begin
                            pc_write      = 1'b1;
                            pc_in_mux_sel = taken ? PC_BEQ_OR_BNE_ADDR : PC_PLUS_4;
                            next_state    = S_FETCH;
                        end
                        OP_JAL, OP_JALR: begin
                            reg_write                = 1'b1;
                            register_data_in_mux_sel = RD_PC_PLUS_4;
                            pc_write                 = 1'b1;
                            pc_in_mux_sel            = opcode == OP_JAL ? PC_JAL_ADDR : PC_ALU_RESULT;
                            next_state               = S_FETCH;
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            next_state = S_TRAP;
`else
                            pc_write   = 1'b1;
                            next_state = S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM_READ: begin
                    mem_req                  = 1'b1;
                    mem_addr_sel             = 1'b1;
                    register_data_in_mux_sel = RD_MEMORY_DATA;
                    next_state               = mem_ready ? S_WRITEBACK : timeout ? S_ERROR : S_MEM_READ;
                end
                S_MEM_WRITE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    pc_write     = mem_ready;
                    next_state   = mem_ready ? S_FETCH : timeout ? S_ERROR : S_MEM_WRITE;
                end
                S_WRITEBACK: begin
                    reg_write                = 1'b1;
                    pc_write                 = 1'b1;
                    register_data_in_mux_sel = opcode == OP_LOAD ? RD_MEMORY_DATA : RD_ALU_RESULT;
                    next_state               = S_FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction expected-cycle model with randomized programs
module tb_multicycle_controller;
    import cpu_pkg::*;
    localparam int CNT_W = 32;

    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic alu_eq = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, use_imm, bus_error;
    logic [2:0] pc_in_mux_sel, sign_extend_type;
    logic [1:0] rd_sel;
    logic [3:0] alu_op;
    logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic illegal_trap;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(CNT_W), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_eq(alu_eq), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_in_mux_sel(pc_in_mux_sel), .reg_write(reg_write),
        .register_data_in_mux_sel(rd_sel), .alu_op(alu_op), .use_imm(use_imm),
        .sign_extend_type(sign_extend_type), .instret(instret), .bus_error(bus_error)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_trap(illegal_trap)
`endif
    );

    // One expected cycle: the inputs to drive and the outputs that must appear.
    typedef struct {
        logic rdy; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic eq;
        logic req, we, asel, irw, pcw; logic [2:0] pcs; logic rw; logic [1:0] rds; logic chk_alu;
    } cyc_t;

    cyc_t plan[$];
    cyc_t cur;
    logic chk_en = 1'b0;
    int tests = 0, fails = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [7:0] exp_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] a; logic i; logic [2:0] s;
        a = ALU_ADD; i = 1'b0; s = SE_I;
        case (op)
            OP_REG:    a = alu_of_f3(f3, f7[5]);
            OP_IMM:    begin a = alu_of_f3(f3, f3 == 3'd5 && f7[5]); i = 1'b1; end
            OP_LOAD:   i = 1'b1;
            OP_STORE:  begin i = 1'b1; s = SE_S; end
            OP_BRANCH: begin a = ALU_SUB; s = SE_B; end
            OP_JAL:    s = SE_J;
            OP_JALR:   i = 1'b1;
            OP_LUI:    begin a = ALU_PASS_B; i = 1'b1; s = SE_U; end
            default: ;
        endcase
        return {a, i, s};
    endfunction

    function automatic cyc_t ir_cyc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic eq);
        cyc_t c;
        c = '{rdy: 1'($urandom), op: op, f3: f3, f7: f7, eq: eq, req: 0, we: 0, asel: 0, irw: 0,
              pcw: 0, pcs: 0, rw: 0, rds: 0, chk_alu: 1};
        return c;
    endfunction

    // Expand one instruction into its expected cycles: fetch waits w1, data waits w2.
    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic eq, input int w1, input int w2);
        cyc_t c;
        for (int i = 0; i <= w1; i++) begin
            c = ir_cyc(7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
            c.chk_alu = 0; c.req = 1; c.rdy = (i == w1); c.irw = (i == w1);
            plan.push_back(c);
        end
        plan.push_back(ir_cyc(op, f3, f7, eq));
        c = ir_cyc(op, f3, f7, eq);
        if (op == OP_BRANCH) begin
            c.pcw = 1;
            c.pcs = ((f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq)) ? PC_BEQ_OR_BNE_ADDR : PC_PLUS_4;
            plan.push_back(c);
        end else if (op == OP_JAL || op == OP_JALR) begin
            c.rw = 1; c.rds = RD_PC_PLUS_4; c.pcw = 1;
            c.pcs = op == OP_JAL ? PC_JAL_ADDR : PC_ALU_RESULT;
            plan.push_back(c);
        end else if (op == OP_LOAD || op == OP_STORE) begin
            plan.push_back(c);
            for (int i = 0; i <= w2; i++) begin
                c = ir_cyc(op, f3, f7, eq);
                c.req = 1; c.asel = 1; c.we = op == OP_STORE; c.rdy = (i == w2);
                c.pcw = op == OP_STORE && i == w2; c.pcs = PC_PLUS_4;
                plan.push_back(c);
            end
            if (op == OP_LOAD) begin
                c = ir_cyc(op, f3, f7, eq);
                c.rw = 1; c.rds = RD_MEMORY_DATA; c.pcw = 1; c.pcs = PC_PLUS_4;
                plan.push_back(c);
            end
        end else if (op == OP_REG || op == OP_IMM || op == OP_LUI) begin
            plan.push_back(c);
            c = ir_cyc(op, f3, f7, eq);
            c.rw = 1; c.rds = RD_ALU_RESULT; c.pcw = 1; c.pcs = PC_PLUS_4;
            plan.push_back(c);
        end else begin
`ifndef ILLEGAL_TRAP_EN
            c.pcw = 1; c.pcs = PC_PLUS_4;
`endif
            plan.push_back(c);
        end
    endtask

    task automatic run_plan(input int n);
        for (int k = 0; k < n && plan.size() > 0; k++) begin
            cur = plan.pop_front();
            mem_ready = cur.rdy; opcode = cur.op; funct3 = cur.f3; funct7 = cur.f7; alu_eq = cur.eq;
            chk_en = 1'b1;
            @(posedge clk); #1;
            if (cur.pcw) exp_instret = exp_instret + 1'b1;
        end
        chk_en = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0; reset = 1'b0; mem_ready = 1'b1; opcode = OP_LUI;
        #1;
        check("rst_ctrl", {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_in_mux_sel,
                           reg_write, rd_sel, bus_error}, '0);
        check("rst_decode", {alu_op, use_imm, sign_extend_type}, '0);
        check("rst_instret", instret, '0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; exp_instret = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl", {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, cur.pcw ? pc_in_mux_sel : 3'b0,
                           reg_write, cur.rw ? rd_sel : 2'b0, bus_error},
                          {cur.req, cur.we, cur.asel, cur.irw, cur.pcw, cur.pcs, cur.rw, cur.rds, 1'b0});
            check("instret", instret, exp_instret);
            if (cur.chk_alu) check("decode", {alu_op, use_imm, sign_extend_type}, exp_dec(cur.op, cur.f3, cur.f7));
        end
    end

    initial begin
        logic [6:0] ops [9];
        int n_ops, n;
        ops = '{OP_REG, OP_IMM, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, 7'h0f};
`ifdef ILLEGAL_TRAP_EN
        n_ops = 8;
`else
        n_ops = 9;
`endif
        do_reset();
        add_instr(OP_IMM, 3'd0, 7'd0, 1'b0, 0, 0);
        check("addi_len", plan.size(), 4);
        run_plan(100);
        check("addi_instret", instret, 1);
        add_instr(OP_LOAD, 3'd2, 7'd0, 1'b0, 0, 3);
        check("lw_len", plan.size(), 8);
        run_plan(100);
        check("lw_instret", instret, 2);
        add_instr(OP_BRANCH, 3'd0, 7'd0, 1'b1, 0, 0);
        check("beq_taken_len", plan.size(), 3);
        run_plan(100);
        add_instr(OP_BRANCH, 3'd0, 7'd0, 1'b0, 0, 0);
        check("beq_not_len", plan.size(), 3);
        run_plan(100);
        add_instr(OP_STORE, 3'd2, 7'd0, 1'b0, 0, 0);
        check("sw_len", plan.size(), 4);
        run_plan(100);
        check("seq_instret", instret, 5);
        repeat (60) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ops[$urandom_range(0, n_ops - 1)];
            f3 = op == OP_BRANCH ? 3'($urandom_range(0, 1)) : 3'($urandom);
            add_instr(op, f3, 7'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
            run_plan(100);
        end
        // Reset asserted between clock edges in the middle of a store.
        add_instr(OP_STORE, 3'd2, 7'd0, 1'b0, 0, 6);
        run_plan(5);
        plan.delete();
        mem_ready = 1'b0;
        #2;
        check("sw_mid_req", {mem_req, mem_we}, 2'b11);
        reset = 1'b0;
        #1;
        check("sw_reset_drop", {mem_req, mem_we}, 2'b00);
        check("sw_reset_instret", instret, 0);
        @(posedge clk); #1;
        reset = 1'b1; exp_instret = '0;
        add_instr(OP_IMM, 3'd0, 7'd0, 1'b0, 0, 0);
        run_plan(100);
        // Memory never answers: sixteen request cycles, then ERROR.
        mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_bus_error", bus_error, 1);
        check("timeout_instret", instret, exp_instret);
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("error_sticky", {bus_error, mem_req, ir_write, pc_write, reg_write, mem_we}, 6'b100000);
        end
        @(posedge clk); #1;
        do_reset();
`ifdef ILLEGAL_TRAP_EN
        add_instr(7'h7f, 3'd0, 7'd0, 1'b0, 0, 0);
        check("trap_len", plan.size(), 3);
        run_plan(100);
        repeat (4) begin
            @(negedge clk);
            check("trap_flag", illegal_trap, 1);
            check("trap_quiet", {mem_req, mem_we, ir_write, pc_write, reg_write}, 0);
        end
        check("trap_instret", instret, 0);
`else
        add_instr(7'h7f, 3'd0, 7'd0, 1'b0, 0, 0);
        check("nop_len", plan.size(), 3);
        run_plan(100);
        check("nop_instret", instret, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
